sam_cmd_encoder: RTL
====================

# sam_cmd_encoder

Host-side instruction encoder for the SAM accelerator's 32-bit command stream: the transmitter that produces the instruction words the SAM decoder consumes. Accepts high-level commands (write burst, read range, go, nop), expands write bursts into one instruction word per 16-bit datum with auto-incrementing addresses, and emits the words on a valid/ready/last stream master. Sits between the host command source (DMA/PS logic) and the SAM wrapper's input stream.

## Interface

Parameters:
- ADDR_W, 14, RAM address width; also the width of cmd_len
- DATA_W, 16, write datum width

Instruction word format (fixed):
- [31:30] opcode: 00 NOP, 01 WRITE, 10 READ, 11 GO
- WRITE: [29:16] address, [15:0] data
- READ: [29:16] start address, [13:0] end address (inclusive); [15:14] = 0
- NOP/GO: [29:0] = 0

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0 WRITE burst, 1 READ, 2 GO, 3 NOP
- cmd_addr  in  ADDR_W  base/start address
- cmd_len  in  ADDR_W  word count minus 1 (WRITE), range length minus 1 (READ); ignored for GO/NOP
- wdata_valid  in  1  write datum present
- wdata_ready  out  1  datum consumed when high with wdata_valid
- wdata  in  DATA_W  write datum
- out_data  out  32  instruction word
- out_valid  out  1  word present
- out_ready  in  1  downstream accepts word
- out_last  out  1  final word of the current command
- busy  out  1  command in progress or output word pending

## Operation

- FSM states: IDLE, WRITE, EMIT (single-word commands and READ), DRAIN.
- IDLE: cmd_ready = 1 when the output register is empty or being accepted this cycle. On accept, latch op, addr, len; WRITE -> WRITE with word counter = 0; READ/GO/NOP -> EMIT.
- EMIT: loads one word into the output register with out_last = 1, then -> DRAIN.
  - READ end address = (cmd_addr + cmd_len) mod 2^ADDR_W (wraps; no error).
- WRITE: wdata_ready = 1 when the output register is empty or out_ready = 1. Each wdata handshake loads {01, addr_cur, wdata} and increments addr_cur mod 2^ADDR_W and the counter. The word whose counter equals cmd_len has out_last = 1, after which -> DRAIN. A missing wdata stalls the FSM; out_valid drops between words and no bubble word is inserted.
- DRAIN: holds until the last word is accepted, then -> IDLE (cmd_ready can rise in that same cycle).
- Output register rules:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid never deasserts without a handshake.
- busy = (state != IDLE) || out_valid.
- Reset (any time, including mid-burst): state -> IDLE, command abandoned, no partial-burst completion.
  - Reset values: out_valid 0, out_last 0, out_data 0, cmd_ready 0, wdata_ready 0, busy 0.
  - cmd_ready rises on the first clock edge after rstn deasserts.

## Timing

- Command accept at edge N: the first word is valid after edge N+1 for EMIT commands, or after the first wdata handshake for WRITE.
- Sustained throughput 1 word/clk in WRITE when wdata_valid and out_ready stay high; a burst of L+1 words takes L+1 cycles plus 1 accept cycle.
- Back-to-back commands: 1 idle cycle maximum between the last word of one command and the first word of the next.
- out_ready low freezes the pipeline. No wdata is consumed while the output register is full and not being accepted.
- wdata_valid outside the WRITE state is ignored (wdata_ready = 0).

## Test plan

- Reset then GO: cmd_op=2 -> single word 0xC000_0000 with out_last=1; busy returns to 0 one cycle after the handshake.
- WRITE burst: addr=0x0010, len=2, wdata 0xAAAA, 0xBBBB, 0xCCCC -> words 0x4010_AAAA, 0x4011_BBBB, 0x4012_CCCC, last only on the third.
- Address wrap: WRITE addr=0x3FFF, len=1 -> 0x7FFF_xxxx then 0x4000_xxxx; READ addr=0x3FFE, len=3 -> 0x BFFE_0001 (end wraps to 0x0001).
- Backpressure: random out_ready toggling and wdata_valid gaps during a 16-word burst -> data stable while stalled, no lost or duplicated words, addresses strictly sequential.
- Reset mid-burst after 3 of 8 words -> out_valid=0 immediately; a following READ addr=0x0005, len=0 -> single word 0x8005_0005.
- Back-to-back commands: NOP then READ, with cmd_valid held high -> 0x0000_0000 (last) then READ word, each with out_last=1, and at most one idle cycle between them.

Source files
------------

// File: rtl/sam_cmd_encoder_if.sv
// Stream bundle for the SAM command encoder: command input, write-data input
// and the 32-bit instruction-word output, each with its own valid/ready pair.
interface sam_cmd_encoder_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Host / command source side.
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len,
        input  cmd_ready,
        output wdata_valid, wdata,
        input  wdata_ready,
        input  out_data, out_valid, out_last,
        output out_ready
    );

    // Encoder side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len,
        output cmd_ready,
        input  wdata_valid, wdata,
        output wdata_ready,
        output out_data, out_valid, out_last,
        input  out_ready
    );
endinterface

// File: rtl/sam_cmd_encoder.sv
// Host-side SAM instruction encoder: turns WRITE/READ/GO/NOP commands into
// 32-bit instruction words, expanding write bursts one word per datum.
module sam_cmd_encoder #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    sam_cmd_encoder_if.slave bus,
    output logic             busy
);
    localparam logic [1:0] CMD_WRITE = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_GO    = 2'd2;

    typedef enum logic [1:0] {IDLE, WRITE, EMIT, DRAIN} state_t;

    state_t            state_q, state_d, cmdState;
    logic              rstDone_q;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addrCur_q, addrCur_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       outData_q, outData_d;
    logic              outValid_q, outValid_d;
    logic              outLast_q, outLast_d;

    logic              outFree, cmdHs, lastWrite, loadWrite, loadEmit;
    logic [ADDR_W-1:0] readEnd;
    logic [DATA_W-1:0] wdataIn;

    assign outFree   = !outValid_q || bus.out_ready;
    assign cmdHs     = bus.cmd_valid && bus.cmd_ready;
    assign lastWrite = (cnt_q == len_q);
    assign readEnd   = addrCur_q + len_q;
    assign wdataIn   = bus.wdata;
    assign cmdState  = (bus.cmd_op == CMD_WRITE) ? WRITE : EMIT;

    // rstDone_q keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rstDone_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rstDone_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmdHs) state_d = cmdState;
            WRITE:   if (loadWrite && lastWrite) state_d = DRAIN;
            EMIT:    if (loadEmit) state_d = DRAIN;
            DRAIN:   if (outFree) state_d = cmdHs ? cmdState : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A new command may be taken in DRAIN while its last word is being accepted.
    always_comb begin
        bus.cmd_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        loadWrite       = 1'b0;
        loadEmit        = 1'b0;
        case (state_q)
            IDLE, DRAIN: bus.cmd_ready = rstDone_q && outFree;
            WRITE: begin
                bus.wdata_ready = outFree;
                loadWrite       = bus.wdata_valid && outFree;
            end
            EMIT:    loadEmit = outFree;
            default: ;
        endcase
    end

    always_comb begin
        op_d       = op_q;
        addrCur_d  = addrCur_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        outData_d  = outData_q;
        if (outValid_q && bus.out_ready) begin
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
        end
        if (cmdHs) begin
            op_d      = bus.cmd_op;
            addrCur_d = bus.cmd_addr;
            len_d     = bus.cmd_len;
            cnt_d     = '0;
        end
        if (loadWrite) begin
            outValid_d = 1'b1;
            outLast_d  = lastWrite;
            outData_d  = {2'b01, addrCur_q, wdataIn};
            addrCur_d  = addrCur_q + ADDR_W'(1);
            cnt_d      = cnt_q + ADDR_W'(1);
        end
        if (loadEmit) begin
            outValid_d = 1'b1;
            outLast_d  = 1'b1;
            case (op_q)
                CMD_READ: outData_d = {2'b10, addrCur_q, 2'b00, readEnd};
                CMD_GO:   outData_d = 32'hC000_0000;
                default:  outData_d = 32'h0000_0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q       <= 2'd0;
            addrCur_q  <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= 32'h0;
        end else begin
            op_q       <= op_d;
            addrCur_q  <= addrCur_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            outData_q  <= outData_d;
        end
    end

    assign bus.out_data  = outData_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;
    assign busy          = (state_q != IDLE) || outValid_q;
endmodule
